// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential signed divider (divide_remainder)
//   and its single-step datapath (div_step).
//   - state_e      : controller states
//   - DEF_*        : default geometry (8-bit divisor, 16-bit dividend)
//   - dw_of()      : dividend width for a given BITWIDTH / double-scale flag
//   - cnt_w_of()   : width of a counter that must hold the value DW
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int DEF_BITWIDTH     = 8;
  localparam int DEF_DOUBLE_SCALE = 1;
  localparam int DEF_DW           = DEF_BITWIDTH * (DEF_DOUBLE_SCALE + 1);
  localparam int DEF_CNT_W        = $clog2(DEF_DW + 1);

  function automatic int dw_of(input int bitwidth, input int double_scale);
    return bitwidth * (double_scale + 1);
  endfunction

  function automatic int cnt_w_of(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration on magnitudes.
//   rem_i : partial remainder (BITWIDTH+1 bits, always < dvs_i)
//   bit_i : next dividend bit, shifted into the remainder LSB
//   dvs_i : divisor magnitude (BITWIDTH+1 bits, 1 .. 2^(BITWIDTH-1))
//   rem_o : partial remainder after the trial subtraction
//   q_o   : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
  parameter int BITWIDTH = 8
) (
  input  logic [BITWIDTH:0] rem_i,
  input  logic              bit_i,
  input  logic [BITWIDTH:0] dvs_i,
  output logic [BITWIDTH:0] rem_o,
  output logic              q_o
);

  // One extra bit so the shift never loses information, even though the
  // incoming remainder is always below the divisor.
  logic [BITWIDTH+1:0] shifted;

  assign shifted = {rem_i, bit_i};

  // Trial subtraction: the difference is kept only when it is non-negative.
  assign q_o   = (shifted >= {1'b0, dvs_i});
  assign rem_o = q_o ? (shifted[BITWIDTH:0] - dvs_i) : shifted[BITWIDTH:0];

endmodule

// File: rtl/divide_remainder.sv
// ---------------------------------------------------------------------------
// divide_remainder
//   Sequential signed divider, restoring, one quotient bit per cycle.
//   dividend = remainder + quotient * divisor; quotient truncates toward
//   zero, remainder takes the dividend's sign.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : operands present          in_ready  : accepting (IDLE)
//   in_dividend   : signed, DW bits           in_divisor: signed, BITWIDTH
//   out_valid     : result present (DONE)     out_ready : result consumed
//   quotient      : low BITWIDTH bits of the signed quotient (not saturated)
//   remainder     : signed remainder, exact
//   overflow      : quotient not representable in BITWIDTH signed bits
//   div_by_zero   : divisor was zero
// ---------------------------------------------------------------------------
module divide_remainder
  import div_pkg::*;
#(
  parameter  int BITWIDTH                 = DEF_BITWIDTH,
  parameter  int IS_BITWIDTH_DOUBLE_SCALE = DEF_DOUBLE_SCALE,
  localparam int DW                       = dw_of(BITWIDTH, IS_BITWIDTH_DOUBLE_SCALE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_dividend,
  input  logic [BITWIDTH-1:0] in_divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] quotient,
  output logic [BITWIDTH-1:0] remainder,
  output logic                overflow,
  output logic                div_by_zero
);

  localparam int CNT_W = cnt_w_of(DW);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]       dq_q, dq_d;       // dividend bits shift out, quotient bits shift in
  logic [BITWIDTH:0]   rem_q, rem_d;
  logic [BITWIDTH:0]   dvs_q, dvs_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [BITWIDTH-1:0] quotient_q, quotient_d;
  logic [BITWIDTH-1:0] remainder_q, remainder_d;
  logic                overflow_q, overflow_d;
  logic                dbz_q, dbz_d;

  // Operand magnitudes: DW bits / BITWIDTH+1 bits unsigned, so the most
  // negative values negate without wrapping.
  logic [DW-1:0]       dvd_mag;
  logic [BITWIDTH:0]   dvs_ext, dvs_mag;
  logic                divisor_zero;

  assign dvd_mag      = in_dividend[DW-1] ? (~in_dividend + 1'b1) : in_dividend;
  assign dvs_ext      = {in_divisor[BITWIDTH-1], in_divisor};
  assign dvs_mag      = dvs_ext[BITWIDTH] ? (~dvs_ext + 1'b1) : dvs_ext;
  assign divisor_zero = (in_divisor == '0);

  logic [BITWIDTH:0]   step_rem;
  logic                step_q;

  div_step #(.BITWIDTH(BITWIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dq_q[DW-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Signed quotient needs DW+1 bits: |-2^(DW-1) / -1| does not fit in DW.
  logic [DW:0]         q_ext, q_signed;
  logic [DW-BITWIDTH+1:0] q_high;         // bits that must all equal the sign

  assign q_ext    = {1'b0, dq_q};
  assign q_signed = q_neg_q ? (~q_ext + 1'b1) : q_ext;
  assign q_high   = q_signed[DW:BITWIDTH-1];

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = divisor_zero ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    cnt_d       = cnt_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cnt_d       = CNT_W'(DW);
          dq_d        = dvd_mag;
          rem_d       = '0;
          dvs_d       = dvs_mag;
          q_neg_d     = in_dividend[DW-1] ^ in_divisor[BITWIDTH-1];
          r_neg_d     = in_dividend[DW-1];
          quotient_d  = '0;
          remainder_d = '0;
          overflow_d  = 1'b0;
          dbz_d       = divisor_zero;
        end
      end
      S_CALC: begin
        // The counter reaching zero costs one idle CALC cycle before FIX.
        if (cnt_q != '0) begin
          rem_d = step_rem;
          dq_d  = {dq_q[DW-2:0], step_q};
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        quotient_d  = q_signed[BITWIDTH-1:0];
        // The final remainder is below |divisor| <= 2^(BITWIDTH-1), so its
        // magnitude always fits in BITWIDTH-1 bits plus sign.
        remainder_d = r_neg_q ? (~rem_q[BITWIDTH-1:0] + 1'b1) : rem_q[BITWIDTH-1:0];
        overflow_d  = ~((&q_high) | ~(|q_high));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      dq_q        <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divide_remainder.sv
// ---------------------------------------------------------------------------
// tb_divide_remainder
//   Directed bench for divide_remainder (BITWIDTH=8, DW=16). A reference
//   model built on integer '/' and '%' supplies the expected result for each
//   accepted operation; a compare process checks every DONE cycle against it.
//   Each directed vector also carries hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_divide_remainder;

  localparam int BW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dividend;
  logic [BW-1:0] in_divisor;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] quotient;
  logic [BW-1:0] remainder;
  logic          overflow;
  logic          div_by_zero;

  divide_remainder #(.BITWIDTH(BW), .IS_BITWIDTH_DOUBLE_SCALE(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] q;
    logic [BW-1:0] r;
    logic          ovf;
    logic          dbz;
  } res_t;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer division (truncating) and modulo.
  function automatic res_t model(input logic signed [DW-1:0] a, input logic signed [BW-1:0] b);
    res_t        m;
    int          qi, ri;
    logic [31:0] qb, rb;
    if (b == 0) begin
      m = '{q: '0, r: '0, ovf: 1'b0, dbz: 1'b1};
    end else begin
      qi    = int'(a) / int'(b);
      ri    = int'(a) % int'(b);
      qb    = qi;
      rb    = ri;
      m.q   = qb[BW-1:0];
      m.r   = rb[BW-1:0];
      m.ovf = (qi > 127) || (qi < -128);
      m.dbz = 1'b0;
    end
    return m;
  endfunction

  // Every DONE cycle: outputs must match the model for the operation in flight.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("model quotient",    32'(quotient),    32'(exp_q[0].q));
        check("model remainder",   32'(remainder),   32'(exp_q[0].r));
        check("model overflow",    32'(overflow),    32'(exp_q[0].ovf));
        check("model div_by_zero", 32'(div_by_zero), 32'(exp_q[0].dbz));
        check("in_ready low in DONE", 32'(in_ready), 32'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Issue one operation, measure latency, check literal results, optionally
  // stall the consumer for 'hold' cycles while offering a new operand.
  task automatic run_op(input logic [DW-1:0] a, input logic [BW-1:0] b, input int exp_lat,
                        input logic [BW-1:0] eq, input logic [BW-1:0] er,
                        input logic eo, input logic ed, input int hold);
    int w;
    int lat;
    @(posedge clk); #1;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      check("accept timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);                      // accepting edge
    exp_q.push_back(model(a, b));
    #1;
    in_valid = 1'b0;
    check("in_ready drops after accept", 32'(in_ready), 32'd0 + 32'(ed ? 1'b0 : 1'b0));
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    // lat counts edges after the accepting one: 18 for a normal divide; a zero
    // divisor reaches DONE on the accepting edge, so out_valid is already up
    // in the very next cycle (lat 0).
    check("latency", 32'(lat), 32'(exp_lat));
    check("literal quotient",    32'(quotient),    32'(eq));
    check("literal remainder",   32'(remainder),   32'(er));
    check("literal overflow",    32'(overflow),    32'(eo));
    check("literal div_by_zero", 32'(div_by_zero), 32'(ed));
    if (hold > 0) begin
      in_dividend = 16'd1234;
      in_divisor  = 8'd5;
      in_valid    = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold in_ready", 32'(in_ready), 32'd0);
        check("hold out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready after handshake", 32'(in_ready), 32'd1);
    check("out_valid after handshake", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b0;
    #1;
    check("reset in_ready",    32'(in_ready),    32'd1);
    check("reset out_valid",   32'(out_valid),   32'd0);
    check("reset quotient",    32'(quotient),    32'd0);
    check("reset remainder",   32'(remainder),   32'd0);
    check("reset overflow",    32'(overflow),    32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //      dividend   divisor  lat  quot   rem    ovf   dbz  hold
    run_op(16'd300,    8'd7,    18, 8'h2A, 8'h06, 1'b0, 1'b0, 0);  // 300/7 = 42 r 6
    run_op(16'hFED4,   8'd7,    18, 8'hD6, 8'hFA, 1'b0, 1'b0, 0);  // -300/7 = -42 r -6
    run_op(16'd300,    8'hF9,   18, 8'hD6, 8'h06, 1'b0, 1'b0, 0);  // 300/-7 = -42 r 6
    run_op(16'hFED4,   8'hF9,   18, 8'h2A, 8'hFA, 1'b0, 1'b0, 0);  // -300/-7 = 42 r -6
    run_op(16'h4000,   8'h80,   18, 8'h80, 8'h00, 1'b0, 1'b0, 0);  // 16384/-128 = -128
    run_op(16'h4000,   8'h01,   18, 8'h00, 8'h00, 1'b1, 1'b0, 0);  // 16384/1 overflows
    run_op(16'd100,    8'h00,    0, 8'h00, 8'h00, 1'b0, 1'b1, 0);  // divide by zero
    run_op(16'h8000,   8'h80,   18, 8'h00, 8'h00, 1'b1, 1'b0, 0);  // -32768/-128 = 256
    run_op(16'h8000,   8'h01,   18, 8'h00, 8'h00, 1'b1, 1'b0, 0);  // -32768/1
    run_op(16'h7FFF,   8'hFF,   18, 8'h01, 8'h00, 1'b1, 1'b0, 0);  // 32767/-1 = -32767
    run_op(16'd7,      8'h80,   18, 8'h00, 8'h07, 1'b0, 1'b0, 0);  // 7/-128 = 0 r 7
    run_op(16'hFC18,   8'h7F,   18, 8'hF9, 8'h91, 1'b0, 1'b0, 10); // -1000/127 = -7 r -111, stalled
    run_op(16'd99,     8'd10,   18, 8'h09, 8'h09, 1'b0, 1'b0, 0);  // accepted after the stall

    // Reset in the middle of CALC discards the operation.
    @(posedge clk); #1;
    in_dividend = 16'd1000;
    in_divisor  = 8'd3;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid-calc reset in_ready",  32'(in_ready),  32'd1);
    check("mid-calc reset out_valid", 32'(out_valid), 32'd0);
    check("mid-calc reset quotient",  32'(quotient),  32'd0);
    check("mid-calc reset remainder", 32'(remainder), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);
    run_op(16'd255,    8'd16,   18, 8'h0F, 8'h0F, 1'b0, 1'b0, 0);  // 255/16 = 15 r 15

    check("results left unconsumed", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
